// File: rtl/usb2ether_pkg.sv
// ============================================================================
// Module      : usb2ether_pkg
// Description : Shared constants, FSM state encodings and a saturating-add
//               helper for the usb2ether FIFO packet sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb2ether_pkg;

  localparam int DEPTH     = 512;                   // FIFO entries, DEPTH-1 usable
  localparam int MAX_LEN   = 511;                   // largest accepted packet
  localparam int MAX_PKTS  = 4;                     // committed-length queue depth
  localparam int MAX_RETRY = 15;                    // replays before discard
  localparam int DATA_W    = 8;
  localparam int LEN_W     = $clog2(DEPTH);
  localparam int RETRY_W   = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_DROP = 2'd2
  } wstate_t;

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_RD    = 3'd1,
    R_WT    = 3'd2,
    R_HOLD  = 3'd3,
    R_FLUSH = 3'd4
  } rstate_t;

  // 16-bit counter add that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_add(input logic [15:0] val, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, val} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb2ether_len_queue.sv
// ============================================================================
// Module      : usb2ether_len_queue
// Description : Small synchronous FIFO holding the lengths of committed RX
//               packets. Simultaneous push and pop are both honoured, even
//               when full. ENTRIES must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb2ether_len_queue
  import usb2ether_pkg::*;
#(
  parameter int ENTRIES = MAX_PKTS,
  parameter int WIDTH   = LEN_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int c_PTR_W = $clog2(ENTRIES);

  logic [WIDTH-1:0]   r_mem [ENTRIES];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (c_PTR_W+1)'(ENTRIES));
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/usb2ether_fifo_ctrl.sv
// ============================================================================
// Module      : usb2ether_fifo_ctrl
// Description : Store-and-forward packet sequencer between the USB RX byte
//               stream and the Ethernet TX MAC. Checkpoints/rolls back RX
//               packets in the FIFO and replays TX packets on collision.
//               Optional statistics counters: define USB2ETHER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb2ether_fifo_ctrl
  import usb2ether_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              ctrl_clear,
  input  logic              rx_valid,
  input  logic              rx_sop,
  input  logic              rx_eop,
  input  logic              rx_abort,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_ready,
  input  logic              tx_retry,
  output logic              tx_valid,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [DATA_W-1:0] tx_data,
  output logic              fifo_write_enable,
  output logic              fifo_write_start,
  output logic              fifo_write_error,
  output logic [DATA_W-1:0] fifo_write_data,
  output logic              fifo_read_enable,
  output logic              fifo_read_start,
  output logic              fifo_read_error,
  output logic              fifo_clear,
  input  logic [DATA_W-1:0] fifo_read_data,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  output logic [15:0]       stat_tx,
  output logic [15:0]       stat_drop,
  output logic [15:0]       stat_retry
);

  // ---------------- length queue ----------------
  logic             w_q_push, w_q_pop, w_q_empty, w_q_full;
  logic [LEN_W-1:0] w_q_din, w_q_head;

  usb2ether_len_queue u_len_queue (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (ctrl_clear),
    .push  (w_q_push && !ctrl_clear),
    .pop   (w_q_pop && !ctrl_clear),
    .din   (w_q_din),
    .head  (w_q_head),
    .empty (w_q_empty),
    .full  (w_q_full)
  );

  // ---------------- write side ----------------
  wstate_t          r_wstate, w_wstate_nxt;
  logic [LEN_W-1:0] r_wcount, w_wcount_nxt;
  logic             w_wr_en, w_wr_start, w_wr_err, w_rx_drop;

  // Write FSM next-state; a sop seen while dropping resynchronises onto the new packet
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wcount_nxt = r_wcount;
    w_wr_en      = 1'b0;
    w_wr_start   = 1'b0;
    w_wr_err     = 1'b0;
    w_rx_drop    = 1'b0;
    w_q_push     = 1'b0;
    w_q_din      = '0;
    case (r_wstate)
      W_IDLE, W_DROP: begin
        if (rx_valid && rx_sop && !rx_abort) begin
          if (!fifo_full && !w_q_full) begin
            w_wr_en      = 1'b1;
            w_wr_start   = 1'b1;
            w_wcount_nxt = LEN_W'(1);
            if (rx_eop) begin
              w_q_push     = 1'b1;
              w_q_din      = LEN_W'(1);
              w_wstate_nxt = W_IDLE;
            end else begin
              w_wstate_nxt = W_DATA;
            end
          end else begin
            w_rx_drop    = 1'b1;
            w_wstate_nxt = rx_eop ? W_IDLE : W_DROP;
          end
        end else if (r_wstate == W_DROP && (rx_abort || (rx_valid && rx_eop))) begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_DATA: begin
        if (rx_abort) begin
          w_wr_err     = 1'b1;
          w_rx_drop    = 1'b1;
          w_wstate_nxt = W_DROP;
        end else if (rx_valid) begin
          if (fifo_full || r_wcount == LEN_W'(MAX_LEN)) begin
            w_wr_err     = 1'b1;
            w_rx_drop    = 1'b1;
            w_wstate_nxt = rx_eop ? W_IDLE : W_DROP;
          end else begin
            w_wr_en      = 1'b1;
            w_wcount_nxt = r_wcount + LEN_W'(1);
            if (rx_eop) begin
              w_q_push     = 1'b1;
              w_q_din      = w_wcount_nxt;
              w_wstate_nxt = W_IDLE;
            end
          end
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM state and byte count
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wstate <= W_IDLE;
      r_wcount <= '0;
    end else if (ctrl_clear) begin
      r_wstate <= W_IDLE;
      r_wcount <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_wcount <= w_wcount_nxt;
    end
  end

  assign fifo_write_enable = w_wr_en && !ctrl_clear;
  assign fifo_write_start  = w_wr_start && !ctrl_clear;
  assign fifo_write_error  = w_wr_err && !ctrl_clear;
  assign fifo_write_data   = rx_data;
  assign fifo_clear        = ctrl_clear;

  // ---------------- read side ----------------
  rstate_t            r_rstate;
  logic [LEN_W-1:0]   r_len, r_remain;
  logic [RETRY_W-1:0] r_retries;
  logic               r_tx_valid, r_tx_sop, r_tx_eop;
  logic [DATA_W-1:0]  r_tx_data;
  logic               w_tx_start, w_retry_active, w_replay, w_flush_go;
  logic               w_sent, w_flush_done;

  assign w_tx_start     = (r_rstate == R_IDLE) && !w_q_empty && !fifo_empty;
  assign w_retry_active = tx_retry && (r_rstate == R_RD || r_rstate == R_WT || r_rstate == R_HOLD);
  assign w_replay       = w_retry_active && (r_retries < RETRY_W'(MAX_RETRY));
  assign w_flush_go     = w_retry_active && !w_replay;
  assign w_sent         = (r_rstate == R_HOLD) && tx_ready && !tx_retry && (r_remain == LEN_W'(1));
  assign w_flush_done   = (r_rstate == R_FLUSH) && (r_remain == LEN_W'(1));
  assign w_q_pop        = w_sent || w_flush_done;

  // Every retry rewinds the FIFO read pointer; a flush then re-reads the whole packet
  assign fifo_read_start  = !ctrl_clear && (w_tx_start || w_replay);
  assign fifo_read_error  = !ctrl_clear && w_retry_active;
  assign fifo_read_enable = !ctrl_clear &&
                            ((r_rstate == R_RD && !tx_retry) || r_rstate == R_FLUSH);

  // Read FSM: fetch, present and hand off one byte at a time; retry rewinds
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rstate   <= R_IDLE;
      r_len      <= '0;
      r_remain   <= '0;
      r_retries  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
      r_tx_data  <= '0;
    end else if (ctrl_clear) begin
      r_rstate   <= R_IDLE;
      r_tx_valid <= 1'b0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
    end else if (w_retry_active) begin
      r_tx_valid <= 1'b0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
      r_remain   <= r_len;
      if (w_replay) begin
        r_retries <= r_retries + RETRY_W'(1);
        r_rstate  <= R_RD;
      end else begin
        r_rstate  <= R_FLUSH;
      end
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_tx_start) begin
            r_len     <= w_q_head;
            r_remain  <= w_q_head;
            r_retries <= '0;
            r_rstate  <= R_RD;
          end
        end
        R_RD: r_rstate <= R_WT;
        R_WT: begin
          r_tx_data  <= fifo_read_data;
          r_tx_valid <= 1'b1;
          r_tx_sop   <= (r_remain == r_len);
          r_tx_eop   <= (r_remain == LEN_W'(1));
          r_rstate   <= R_HOLD;
        end
        R_HOLD: begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_tx_sop   <= 1'b0;
            r_tx_eop   <= 1'b0;
            if (r_remain == LEN_W'(1)) begin
              r_rstate <= R_IDLE;
            end else begin
              r_remain <= r_remain - LEN_W'(1);
              r_rstate <= R_RD;
            end
          end
        end
        R_FLUSH: begin
          if (r_remain == LEN_W'(1)) r_rstate <= R_IDLE;
          else                       r_remain <= r_remain - LEN_W'(1);
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_sop   = r_tx_sop;
  assign tx_eop   = r_tx_eop;
  assign tx_data  = r_tx_data;

  // ---------------- statistics ----------------
`ifdef USB2ETHER_STATS_EN
  logic [15:0] r_stat_tx, r_stat_drop, r_stat_retry;
  logic [1:0]  w_drop_inc;

  assign w_drop_inc = {1'b0, w_rx_drop} + {1'b0, w_flush_go};

  // Saturating event counters; ctrl_clear suppresses events but keeps totals
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_stat_tx    <= '0;
      r_stat_drop  <= '0;
      r_stat_retry <= '0;
    end else if (!ctrl_clear) begin
      r_stat_tx    <= sat_add(r_stat_tx, {1'b0, w_sent});
      r_stat_drop  <= sat_add(r_stat_drop, w_drop_inc);
      r_stat_retry <= sat_add(r_stat_retry, {1'b0, w_replay});
    end
  end

  assign stat_tx    = r_stat_tx;
  assign stat_drop  = r_stat_drop;
  assign stat_retry = r_stat_retry;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_rx_drop & w_flush_go;
  assign stat_tx    = '0;
  assign stat_drop  = '0;
  assign stat_retry = '0;
`endif

endmodule

`default_nettype wire
